// File: rtl/pwm_rgb.sv
`default_nettype none
// ============================================================================
// Module   : pwm_rgb
// Brief    : One colour channel of a hue-wheel LED driver: a six-segment
//            gradient sequencer feeding an R-bit PWM comparator.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_rgb #(
    parameter int          R           = 8,
    parameter int          GRAD_THRESH = 100,
    parameter logic [31:0] DVSR        = 32'd10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] delay,
    output logic       rainbow_out
);

    localparam int             c_gw        = (GRAD_THRESH > 1) ? $clog2(GRAD_THRESH) : 1;
    localparam logic [c_gw-1:0] c_grad_last = c_gw'(GRAD_THRESH - 1);
    localparam logic [31:0]    c_pwm_last  = DVSR - 32'd1;
    localparam logic [R-1:0]   c_step_last = {R{1'b1}};
    localparam logic [R:0]     c_duty_full = {1'b1, {R{1'b0}}};

    logic [c_gw-1:0] r_grad_div;
    logic [R-1:0]    r_step;
    logic [2:0]      r_seg;
    logic [31:0]     r_pwm_div;
    logic [R-1:0]    r_pwm_cnt;

    logic            w_grad_tick;
    logic            w_pwm_tick;
    logic [2:0]      w_delay_m;
    logic [3:0]      w_phase_raw;
    logic [2:0]      w_phase;
    logic [R:0]      w_duty;

    assign w_grad_tick = (r_grad_div == c_grad_last);
    assign w_pwm_tick  = (r_pwm_div == c_pwm_last);

    // Gradient sequencer: prescaler -> step -> segment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grad_div <= '0;
            r_step     <= '0;
            r_seg      <= '0;
        end else begin
            if (w_grad_tick) begin
                r_grad_div <= '0;
                r_step     <= r_step + R'(1);
                if (r_step == c_step_last) begin
                    r_seg <= (r_seg == 3'd5) ? 3'd0 : r_seg + 3'd1;
                end
            end else begin
                r_grad_div <= r_grad_div + c_gw'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm_div <= '0;
            r_pwm_cnt <= '0;
        end else begin
            if (w_pwm_tick) begin
                r_pwm_div <= '0;
                r_pwm_cnt <= r_pwm_cnt + R'(1);
            end else begin
                r_pwm_div <= r_pwm_div + 32'd1;
            end
        end
    end

    // Lag the segment by delay (mod 6) to get this channel's phase
    assign w_delay_m   = (delay >= 3'd6) ? delay - 3'd6 : delay;
    assign w_phase_raw = {1'b0, r_seg} + 4'd6 - {1'b0, w_delay_m};
    assign w_phase     = (w_phase_raw >= 4'd6) ? 3'(w_phase_raw - 4'd6) : w_phase_raw[2:0];

    always_comb begin
        w_duty = '0;
        case (w_phase)
            3'd0:    w_duty = {1'b0, r_step};
            3'd1,
            3'd2:    w_duty = c_duty_full;
            3'd3:    w_duty = {1'b0, ~r_step};
            default: w_duty = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rainbow_out <= 1'b0;
        end else begin
            rainbow_out <= ({1'b0, r_pwm_cnt} < w_duty);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_rgb.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_rgb
// Brief    : Self-checking bench for pwm_rgb; three channels (lags 0/2/4)
//            checked against directed vectors and a closed-form timing model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_rgb;

    localparam int R      = 4;
    localparam int GT     = 32;
    localparam int DV     = 2;
    localparam int NS     = 1 << R;
    localparam int SEGLEN = GT * NS;
    localparam int HUE    = 6 * SEGLEN;
    localparam int NWIN   = HUE / GT;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] d_g = 3'd0;
    logic [2:0] d_b = 3'd2;
    logic [2:0] d_r = 3'd4;
    logic       out_g, out_b, out_r;

    int checks   = 0;
    int failures = 0;

    pwm_rgb #(.R(R), .GRAD_THRESH(GT), .DVSR(32'(DV))) u_green (
        .clk(clk), .rst(rst), .delay(d_g), .rainbow_out(out_g));
    pwm_rgb #(.R(R), .GRAD_THRESH(GT), .DVSR(32'(DV))) u_blue (
        .clk(clk), .rst(rst), .delay(d_b), .rainbow_out(out_b));
    pwm_rgb #(.R(R), .GRAD_THRESH(GT), .DVSR(32'(DV))) u_red (
        .clk(clk), .rst(rst), .delay(d_r), .rainbow_out(out_r));

    always #4 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        int   ch;
        int   edg;
        logic exp;
    } vec_t;

    vec_t tbl[18];

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic pick(input int ch);
        case (ch)
            0:       return out_g;
            1:       return out_b;
            default: return out_r;
        endcase
    endfunction

    // Duty for a state k clocks after reset, derived from elapsed time only
    function automatic int duty_at(input int k, input logic [2:0] d);
        int seg, s, p;
        seg = (k / SEGLEN) % 6;
        s   = (k / GT) % NS;
        p   = (seg + 6 - (int'(d) % 6)) % 6;
        case (p)
            0:       return s;
            1, 2:    return NS;
            3:       return NS - 1 - s;
            default: return 0;
        endcase
    endfunction

    function automatic logic model(input int k, input logic [2:0] d);
        return ((k / DV) % NS) < duty_at(k, d);
    endfunction

    int e;
    int hi[NWIN];

    initial begin
        // {channel 0=g 1=b 2=r, edges after release, expected output}
        tbl[0]  = '{0, 1,    1'b0};
        tbl[1]  = '{1, 1,    1'b0};
        tbl[2]  = '{2, 1,    1'b1};
        tbl[3]  = '{0, 321,  1'b1};
        tbl[4]  = '{0, 340,  1'b1};
        tbl[5]  = '{0, 341,  1'b0};
        tbl[6]  = '{0, 513,  1'b1};
        tbl[7]  = '{1, 513,  1'b0};
        tbl[8]  = '{2, 1025, 1'b0};
        tbl[9]  = '{0, 1537, 1'b1};
        tbl[10] = '{1, 1537, 1'b1};
        tbl[11] = '{0, 1567, 1'b0};
        tbl[12] = '{0, 1601, 1'b1};
        tbl[13] = '{0, 1627, 1'b0};
        tbl[14] = '{1, 2101, 1'b1};
        tbl[15] = '{2, 2601, 1'b1};
        tbl[16] = '{0, 3073, 1'b0};
        tbl[17] = '{2, 3073, 1'b1};

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check_bit("rst_hold_g", out_g, 1'b0);
        check_bit("rst_hold_b", out_b, 1'b0);
        check_bit("rst_hold_r", out_r, 1'b0);
        rst = 1'b0;

        e = 0;
        for (int i = 0; i < 18; i++) begin
            while (e < tbl[i].edg) begin
                @(posedge clk);
                e++;
            end
            #1;
            check_bit($sformatf("vec%0d_ch%0d_e%0d", i, tbl[i].ch, tbl[i].edg),
                      pick(tbl[i].ch), tbl[i].exp);
        end

        // Asynchronous reset landing between clock edges
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_bit("async_rst_g", out_g, 1'b0);
        check_bit("async_rst_b", out_b, 1'b0);
        check_bit("async_rst_r", out_r, 1'b0);
        repeat (2) begin
            @(negedge clk);
            check_bit("rst_held_r", out_r, 1'b0);
        end
        rst = 1'b0;

        // Full hue cycle after restart, every clock on every channel
        for (int w = 0; w < NWIN; w++) hi[w] = 0;
        for (int k = 0; k < HUE; k++) begin
            @(posedge clk);
            #1;
            check_bit($sformatf("sweep_g_k%0d", k), out_g, model(k, d_g));
            check_bit($sformatf("sweep_b_k%0d", k), out_b, model(k, d_b));
            check_bit($sformatf("sweep_r_k%0d", k), out_r, model(k, d_r));
            hi[k / GT] += int'(out_g);
        end

        // High time per step window: duty*DVSR clocks of each PWM period
        for (int w = 0; w < NWIN; w++) begin
            check_int($sformatf("hightime_g_w%0d", w), hi[w], DV * duty_at(w * GT, 3'd0));
        end

        // Delay changes mid-run take effect on the next edge; 6/7 fold to 0/1
        begin
            logic [2:0] dseq[4];
            int k;
            dseq[0] = 3'd7;
            dseq[1] = 3'd6;
            dseq[2] = 3'd4;
            dseq[3] = 3'd2;
            k = HUE;
            for (int j = 0; j < 4; j++) begin
                d_g = dseq[j];
                for (int c = 0; c < 20; c++) begin
                    @(posedge clk);
                    #1;
                    check_bit($sformatf("delay%0d_k%0d", dseq[j], k), out_g, model(k, d_g));
                    k++;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pwm_rgb.md
Name: pwm_rgb

Overview:
- One colour channel of a rainbow (hue-wheel) LED driver.
- A slow gradient sequencer steps through 6 hue segments. Each segment carries a per-channel duty profile: ramp-up, full, full, ramp-down, off, off.
- The duty drives an R-bit PWM comparator.
- Three instances share clk/rst and differ only in `delay`, which sets the segment lag: green=0, blue=2, red=4.

Parameters:
- R, 8: PWM/gradient resolution in bits. PWM period is 2^R ticks; each segment has 2^R gradient steps.
- grad_thresh, 100: clocks per gradient step (must be ≥1).
- dvsr, 32-bit, 10: clocks per PWM counter tick (must be ≥1). PWM period = dvsr·2^R clocks.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- delay, input, 3: segment lag, 0..5. Treated as static; values 6 and 7 are reduced mod 6 (to 0 and 1).
- rainbow_out, input/output role: output, 1: registered PWM output.

Behaviour:
- Reset (async, active-high) clears all of the following to 0: grad_div, step, seg, pwm_div, pwm_cnt, rainbow_out. Registers hold 0 while rst is high.
- Gradient prescaler grad_div:
  - Counts 0..grad_thresh-1; at grad_thresh-1 it wraps to 0 and asserts grad_tick for one cycle.
- step (R bits):
  - Increments on grad_tick.
  - On grad_tick with step = 2^R-1, step wraps to 0 and seg advances.
- seg (3 bits):
  - Runs 0..5 and wraps 5→0.
  - Segment length = grad_thresh·2^R clocks; full hue cycle = 6× that.
- Phase: p = (seg + 6 − (delay mod 6)) mod 6.
- Duty (R+1 bits), by phase:
  - p=0: duty = step (ramp up)
  - p=1, p=2: duty = 2^R (always on)
  - p=3: duty = 2^R−1−step (ramp down)
  - p=4, p=5: duty = 0
- PWM prescaler pwm_div:
  - Counts 0..dvsr-1; at dvsr-1 it wraps and pwm_cnt (R bits) increments, wrapping 2^R-1→0.
- Output: rainbow_out <= (pwm_cnt < duty), registered. It is computed from the current register values, giving 1-clock latency.
- Limit cases:
  - duty=0 → constant 0.
  - duty=2^R → constant 1.
  - duty=k → high for k·dvsr clocks of each dvsr·2^R-clock period.
- Post-reset values (first edge after rst falls):
  - delay=0: p=0, duty 0 → 0.
  - delay=2: p=4 → 0.
  - delay=4: p=2 → 1.
- Resulting colours with G/B/R lags 0/2/4:
  - seg0 red, seg1 yellow→red fading, seg2 green, seg3 cyan, seg4 blue, seg5 magenta.
- Reset mid-operation: immediate return to all-zero state. Restart is identical to power-up.
- delay change mid-run: takes effect on the next clock. No glitch filtering required.
- All counters are free-running. There is no enable and no handshake.

Test Plan (R=8, grad_thresh=100, dvsr=10, clk period 8 ns):
- Reset, then release: rainbow_out stays 0 during rst. After release: delay=4 goes to 1 at the first edge; delay=0 and delay=2 stay 0.
- Gradient stepping, delay=0: step increments every 100 clocks. At step=128 (12,800 clocks after reset) measure one 2560-clock PWM period → high for exactly 1280 clocks.
- Full segment, delay=2 (blue, p=1/2): seg=3 starts at clock 76,800; rainbow_out is constantly 1 through clock 128,000 (end of seg4).
- Ramp down, delay=0 in seg3: at step=0 high 2550/2560 clocks. Duty decreases by 1 each 100 clocks. Last step gives 0 high time. seg4/seg5 gives constant 0.
- Wrap and phasing: after 153,600 clocks seg returns to 0. Across one hue cycle, verify against the phase formula:
  - red is 1 in seg0/seg5 and 0 in seg2/seg3
  - green is 1 in seg1/seg2
  - blue is 1 in seg3/seg4
- Async reset mid-run: assert rst at clock 50,000, not clock-aligned. Outputs drop to 0 immediately. After release the sequence repeats the post-reset values and timing exactly.
